qspi_psram_ctrl: RTL
====================

Name: qspi_psram_ctrl

Overview:
- Synchronous bus-to-QSPI master bridge sitting directly upstream of the QSPI PSRAM in the SoC.
- Converts single byte/half/word requests into PSRAM transactions:
  - unlock: 'h35, sent on io0
  - quad read: 'hEB
  - quad write: 'h38
- Generates SCK, chip select and per-line output enables; returns read data on a valid-only response channel.

Parameters:
- DUMMY_CYCLES, 6, SCK cycles between the last address nibble and the first read nibble.
- CS_GAP, 2, minimum SCK-period count with cs_on high between transactions, including the trailing pulse.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  synchronous active-high reset
- req_valid_i  in  1  request valid
- req_ready_o  out  1  request accepted when valid&ready
- req_we_i  in  1  1=write, 0=read
- req_adr_i  in  24  byte address
- req_size_i  in  2  0=1 byte, 1=2 bytes, 2=4 bytes; 3 is treated as 4 bytes
- req_wdat_i  in  32  write data, little-endian, byte0=[7:0]
- rsp_valid_o  out  1  one-cycle pulse, read data valid
- rsp_rdat_o  out  32  read data, little-endian, unused bytes zero
- sck_o  out  1  serial clock
- cs_on  out  1  active-low chip select
- io_o  out  4  io3..io0 output values
- io_oe_o  out  4  per-line output enable
- io_i  in  4  io3..io0 sampled values
- stat_rd_o  out  32  completed read count (see Optional Feature)
- stat_wr_o  out  32  completed write count

Behaviour:
- SCK = clk_i/2 via phase bit ph.
  - ph=0: sck_o=0; io_o/io_oe_o update on entry to this phase.
  - ph=1: sck_o=1.
  - io_i is registered on the clk edge that sets sck_o 0->1.
  - Outside transactions: sck_o=0, except during the trailing pulse.
- Reset values:
  - sck_o=0, cs_on=1, io_o=0, io_oe_o=0
  - req_ready_o=0, rsp_valid_o=0, rsp_rdat_o=0, stats=0
  - state=UNLOCK
- States: UNLOCK, IDLE, CMD, ADR, DUMMY, RDATA, WDATA, TRAIL, GAP.
- UNLOCK: cs_on=0; shift 'h35 MSB-first on io0 only (io_oe_o=4'b0001) for 8 SCK cycles. Then TRAIL, GAP, IDLE. Runs exactly once per reset.
- IDLE: req_ready_o=1. On valid&ready:
  - latch we, adr, size, wdat
  - byte count N = 1/2/4
  - go to CMD
  - req_ready_o is 0 in every other state.
- CMD: cs_on=0; 'hEB or 'h38 MSB-first on io0, io_oe_o=4'b0001, 8 SCK cycles.
- ADR: io_oe_o=4'hF; 6 SCK cycles, adr[23:20] first. Next state is WDATA if we, else DUMMY.
- DUMMY: io_oe_o=0; DUMMY_CYCLES SCK cycles.
- RDATA: io_oe_o=0; 2*N SCK cycles, high nibble first per byte, byte k placed at rsp_rdat_o[8k+7:8k].
- WDATA: io_oe_o=4'hF; 2*N SCK cycles, high nibble first, byte0 first.
- Transaction totals in SCK cycles:
  - read: 8+6+DUMMY_CYCLES+2N (word: 28)
  - write: 8+6+2N (word: 22)
- TRAIL: cs_on=1, io_oe_o=0, exactly one full SCK pulse. The PSRAM samples CS on SCK edges, so this pulse is mandatory.
- GAP: cs_on=1, sck_o=0 for the remaining CS_GAP-1 SCK periods.
  - Read: rsp_valid_o pulses one clk on GAP exit; rsp_rdat_o holds until the next read completes.
  - Then IDLE.
- Write: no response; completion is signalled by req_ready_o returning.
- Address wrap: 24-bit, no carry check. 'hFFFFFF + 1 wraps to 0 inside the PSRAM; the controller emits only the start address.
- rst_i mid-transaction:
  - next clk forces the reset values above (cs_on=1 immediately, no trailing pulse)
  - state=UNLOCK, unlock reissued
  - any response pending at reset is discarded
- req_valid_i outside IDLE is ignored (held by the requester).

Optional Feature:
- Macro QSPI_PSRAM_CTRL_STATS_EN.
- Defined: stat_rd_o / stat_wr_o increment by 1 on each completed read/write, at GAP exit. They wrap at 2^32, reset to 0, and exclude the unlock sequence.
- Undefined: both outputs tied to 0 and no counter flops.

Test Plan:
- Reset release, with the PSRAM model attached -> 'h35 on io0 (io0 pattern 0,0,1,1,0,1,0,1) and 8 SCK pulses with cs_on=0, then exactly one SCK pulse with cs_on=1, then req_ready_o=1.
- Write word adr='h000010, wdat='hDDCCBBAA -> 22 SCK cycles with cs_on low; nibbles after the address are A,A,B,B,C,C,D,D. Model memory 0x10..0x13 = AA,BB,CC,DD.
- Read word adr='h000010 after the above -> rsp_valid_o single pulse, rsp_rdat_o='hDDCCBBAA, 28 SCK cycles with cs_on low, io_oe_o=0 during DUMMY and RDATA.
- Read byte adr='h000012 -> rsp_rdat_o='h000000CC, 22 SCK cycles; half read adr='h000011 -> 'h0000CCBB.
- Assert rst_i at SCK cycle 15 of a word write -> cs_on=1 on the next clk, unlock resent, subsequent read of 0x10 completes normally.
- With QSPI_PSRAM_CTRL_STATS_EN, run 3 writes and 2 reads -> stat_wr_o=3, stat_rd_o=2; without the macro, both stay 0.

Source files
------------

// File: rtl/qspi_psram_ctrl_if.sv
// Request/response bus between a requester and qspi_psram_ctrl.
// The requester uses the master modport and the controller uses the slave modport.
interface qspi_psram_ctrl_if;
   logic        req_valid_i;
   logic        req_ready_o;
   logic        req_we_i;
   logic [23:0] req_adr_i;
   logic [1:0]  req_size_i;
   logic [31:0] req_wdat_i;
   logic        rsp_valid_o;
   logic [31:0] rsp_rdat_o;

   modport master (
      output req_valid_i, req_we_i, req_adr_i, req_size_i, req_wdat_i,
      input  req_ready_o, rsp_valid_o, rsp_rdat_o
   );

   modport slave (
      input  req_valid_i, req_we_i, req_adr_i, req_size_i, req_wdat_i,
      output req_ready_o, rsp_valid_o, rsp_rdat_o
   );
endinterface

// File: rtl/qspi_psram_ctrl.sv
// Bus-to-QSPI PSRAM bridge: issues unlock (0x35) after reset, then quad
// read (0xEB) / quad write (0x38) transactions for 1/2/4-byte requests.
// SCK runs at clk_i/2. Each SCK cycle is a drive half (sck low, io updated)
// followed by a sample half (sck high, io_i captured).
// Optional completion counters: define QSPI_PSRAM_CTRL_STATS_EN.
module qspi_psram_ctrl #(
   parameter int unsigned DUMMY_CYCLES = 6,
   parameter int unsigned CS_GAP       = 2
) (
   input  logic                clk_i,
   input  logic                rst_i,
   qspi_psram_ctrl_if.slave    bus,
   output logic                sck_o,
   output logic                cs_on,
   output logic [3:0]          io_o,
   output logic [3:0]          io_oe_o,
   input  logic [3:0]          io_i,
   output logic [31:0]         stat_rd_o,
   output logic [31:0]         stat_wr_o
);

   localparam logic [3:0] UNLOCK = 4'd0;
   localparam logic [3:0] IDLE   = 4'd1;
   localparam logic [3:0] CMD    = 4'd2;
   localparam logic [3:0] ADR    = 4'd3;
   localparam logic [3:0] DUMMY  = 4'd4;
   localparam logic [3:0] RDATA  = 4'd5;
   localparam logic [3:0] WDATA  = 4'd6;
   localparam logic [3:0] TRAIL  = 4'd7;
   localparam logic [3:0] GAP    = 4'd8;

   localparam logic [7:0] UNLOCK_CMD = 8'h35;
   localparam logic [7:0] READ_CMD   = 8'hEB;
   localparam logic [7:0] WRITE_CMD  = 8'h38;

   logic [3:0]  state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic        ph_q, ph_d;
   logic        unl_q, unl_d;
   logic        we_q, we_d;
   logic [23:0] adr_q, adr_d;
   logic [2:0]  nb_q, nb_d;
   logic [31:0] wdat_q, wdat_d;
   logic [31:0] rbuf_q, rbuf_d;
   logic        sck_q, sck_d;
   logic        cs_q, cs_d;
   logic [3:0]  io_q, io_d;
   logic [3:0]  oe_q, oe_d;
   logic        ready_q, ready_d;
   logic        rsp_valid_q, rsp_valid_d;
   logic [31:0] rsp_rdat_q, rsp_rdat_d;

   logic [15:0] len;
   logic [3:0]  nxt;
   logic [7:0]  tmp8;
   logic [23:0] tmp24;
   logic [31:0] tmp32;

`ifdef QSPI_PSRAM_CTRL_STATS_EN
   logic [31:0] stat_rd_q, stat_rd_d;
   logic [31:0] stat_wr_q, stat_wr_d;
`endif

   // Next-state, pin and response logic; counters advance on the sample half.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      ph_d        = ph_q;
      unl_d       = unl_q;
      we_d        = we_q;
      adr_d       = adr_q;
      nb_d        = nb_q;
      wdat_d      = wdat_q;
      rbuf_d      = rbuf_q;
      sck_d       = sck_q;
      cs_d        = cs_q;
      io_d        = io_q;
      oe_d        = oe_q;
      ready_d     = ready_q;
      rsp_valid_d = 1'b0;
      rsp_rdat_d  = rsp_rdat_q;
      tmp8        = '0;
      tmp24       = '0;
      tmp32       = '0;
`ifdef QSPI_PSRAM_CTRL_STATS_EN
      stat_rd_d   = stat_rd_q;
      stat_wr_d   = stat_wr_q;
`endif

      case (state_q)
         UNLOCK:       begin len = 16'd8; nxt = TRAIL; end
         CMD:          begin len = 16'd8; nxt = ADR;   end
         ADR: begin
            len = 16'd6;
            nxt = we_q ? WDATA : ((DUMMY_CYCLES == 0) ? RDATA : DUMMY);
         end
         DUMMY:        begin len = 16'(DUMMY_CYCLES); nxt = RDATA; end
         RDATA, WDATA: begin len = {12'd0, nb_q, 1'b0}; nxt = TRAIL; end
         TRAIL:        begin len = 16'd1; nxt = (CS_GAP > 1) ? GAP : IDLE; end
         GAP:          begin len = 16'(CS_GAP - 1); nxt = IDLE; end
         default:      begin len = 16'd1; nxt = IDLE; end
      endcase

      if (state_q == IDLE) begin
         sck_d = 1'b0;
         if (bus.req_valid_i && ready_q) begin
            we_d    = bus.req_we_i;
            adr_d   = bus.req_adr_i;
            wdat_d  = bus.req_wdat_i;
            rbuf_d  = '0;
            ready_d = 1'b0;
            state_d = CMD;
            cnt_d   = '0;
            case (bus.req_size_i)
               2'd0:    nb_d = 3'd1;
               2'd1:    nb_d = 3'd2;
               default: nb_d = 3'd4;
            endcase
         end
      end else if (ph_q) begin
         // drive half: SCK low, present the bit/nibble for cnt_q of state_q
         ph_d  = 1'b0;
         sck_d = 1'b0;
         case (state_q)
            UNLOCK: begin
               tmp8 = UNLOCK_CMD << cnt_q[2:0];
               cs_d = 1'b0;
               oe_d = 4'b0001;
               io_d = {3'b000, tmp8[7]};
            end
            CMD: begin
               tmp8 = (we_q ? WRITE_CMD : READ_CMD) << cnt_q[2:0];
               cs_d = 1'b0;
               oe_d = 4'b0001;
               io_d = {3'b000, tmp8[7]};
            end
            ADR: begin
               tmp24 = adr_q << {cnt_q[2:0], 2'b00};
               cs_d  = 1'b0;
               oe_d  = 4'hF;
               io_d  = tmp24[23:20];
            end
            WDATA: begin
               tmp32 = wdat_q >> {cnt_q[2:1], 3'b000};
               cs_d  = 1'b0;
               oe_d  = 4'hF;
               io_d  = cnt_q[0] ? tmp32[3:0] : tmp32[7:4];
            end
            DUMMY, RDATA: begin
               cs_d = 1'b0;
               oe_d = 4'h0;
               io_d = 4'h0;
            end
            default: begin
               cs_d = 1'b1;
               oe_d = 4'h0;
               io_d = 4'h0;
            end
         endcase
      end else begin
         // sample half: SCK high (except during GAP), capture and advance
         ph_d  = 1'b1;
         sck_d = (state_q != GAP);
         if (state_q == RDATA) begin
            rbuf_d[{cnt_q[2:1], ~cnt_q[0], 2'b00} +: 4] = io_i;
         end
         if (cnt_q == len - 16'd1) begin
            cnt_d   = '0;
            state_d = nxt;
            if (nxt == IDLE) begin
               ready_d = 1'b1;
               unl_d   = 1'b0;
               if (!unl_q) begin
                  if (we_q) begin
`ifdef QSPI_PSRAM_CTRL_STATS_EN
                     stat_wr_d = stat_wr_q + 32'd1;
`endif
                  end else begin
                     rsp_valid_d = 1'b1;
                     rsp_rdat_d  = rbuf_q;
`ifdef QSPI_PSRAM_CTRL_STATS_EN
                     stat_rd_d   = stat_rd_q + 32'd1;
`endif
                  end
               end
            end
         end else begin
            cnt_d = cnt_q + 16'd1;
         end
      end
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= UNLOCK;
         cnt_q       <= '0;
         ph_q        <= 1'b1;
         unl_q       <= 1'b1;
         we_q        <= 1'b0;
         adr_q       <= '0;
         nb_q        <= 3'd1;
         wdat_q      <= '0;
         rbuf_q      <= '0;
         sck_q       <= 1'b0;
         cs_q        <= 1'b1;
         io_q        <= '0;
         oe_q        <= '0;
         ready_q     <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_rdat_q  <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         ph_q        <= ph_d;
         unl_q       <= unl_d;
         we_q        <= we_d;
         adr_q       <= adr_d;
         nb_q        <= nb_d;
         wdat_q      <= wdat_d;
         rbuf_q      <= rbuf_d;
         sck_q       <= sck_d;
         cs_q        <= cs_d;
         io_q        <= io_d;
         oe_q        <= oe_d;
         ready_q     <= ready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdat_q  <= rsp_rdat_d;
      end
   end

`ifdef QSPI_PSRAM_CTRL_STATS_EN
   // Completion counters, excluding the unlock sequence.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         stat_rd_q <= '0;
         stat_wr_q <= '0;
      end else begin
         stat_rd_q <= stat_rd_d;
         stat_wr_q <= stat_wr_d;
      end
   end

   assign stat_rd_o = stat_rd_q;
   assign stat_wr_o = stat_wr_q;
`else
   assign stat_rd_o = '0;
   assign stat_wr_o = '0;
`endif

   assign sck_o           = sck_q;
   assign cs_on           = cs_q;
   assign io_o            = io_q;
   assign io_oe_o         = oe_q;
   assign bus.req_ready_o = ready_q;
   assign bus.rsp_valid_o = rsp_valid_q;
   assign bus.rsp_rdat_o  = rsp_rdat_q;

endmodule
